// File: rtl/joy_pkg.sv
// rtl/joy_pkg.sv - shared types and constants for the joystick chain scanner
package joy_pkg;

  // Scan sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_GAP    = 3'd4
  } joy_state_t;

  // Default chain length: two players x 12 buttons
  localparam int JOY_NBITS = 24;

  // Frame bit positions for the 24-bit two-player map (first-shifted bit = bit 23)
  localparam int JOY_P1_UP     = 23;
  localparam int JOY_P1_DOWN   = 22;
  localparam int JOY_P1_LEFT   = 21;
  localparam int JOY_P1_RIGHT  = 20;
  localparam int JOY_P1_A      = 19;
  localparam int JOY_P1_B      = 18;
  localparam int JOY_P1_C      = 17;
  localparam int JOY_P1_D      = 16;
  localparam int JOY_P1_START  = 15;
  localparam int JOY_P1_SELECT = 14;
  localparam int JOY_P1_L      = 13;
  localparam int JOY_P1_R      = 12;
  localparam int JOY_P2_UP     = 11;
  localparam int JOY_P2_DOWN   = 10;
  localparam int JOY_P2_LEFT   = 9;
  localparam int JOY_P2_RIGHT  = 8;
  localparam int JOY_P2_A      = 7;
  localparam int JOY_P2_B      = 6;
  localparam int JOY_P2_C      = 5;
  localparam int JOY_P2_D      = 4;
  localparam int JOY_P2_START  = 3;
  localparam int JOY_P2_SELECT = 2;
  localparam int JOY_P2_L      = 1;
  localparam int JOY_P2_R      = 0;

endpackage

// File: rtl/joy_tick_gen.sv
// rtl/joy_tick_gen.sv - clock-enable divider for the shift-clock half periods
module joy_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_cnt;

  // Free-running divider while run is high; held at zero otherwise so each scan starts phase-aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run) begin
      r_cnt <= '0;
    end else if (r_cnt == DIV_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = run && (r_cnt == DIV_LAST);

endmodule

// File: rtl/joy_scan_ctrl.sv
// rtl/joy_scan_ctrl.sv - joystick shift-register chain sequencer with scan debounce
module joy_scan_ctrl
  import joy_pkg::*;
#(
  parameter int NBITS    = JOY_NBITS,
  parameter int CLK_DIV  = 16,
  parameter int GAP_CYC  = 256,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             scan_req,
  input  logic             joy_data,
  output logic             joy_clk,
  output logic             joy_load_n,
  output logic [NBITS-1:0] frame_data,
  output logic             frame_valid,
  output logic             frame_changed,
  output logic             busy
);

  localparam int BW = $clog2(NBITS + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [SW-1:0] DB_MAX   = SW'(DEBOUNCE);
  localparam logic [SW-1:0] DB_ONE   = SW'(1);

  joy_state_t       r_state;
  joy_state_t       w_state_nxt;
  logic             r_half;
  logic             w_half_nxt;
  logic             r_load_tick;
  logic [BW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [NBITS-1:0] r_sreg;
  logic [NBITS-1:0] r_raw_prev;
  logic [SW-1:0]    r_stable_cnt;
  logic [NBITS-1:0] r_frame_data;
  logic             r_frame_valid;
  logic             r_frame_changed;
  logic             r_busy;
  logic             r_joy_clk;
  logic             r_joy_load_n;

  logic             w_run;
  logic             w_tick;
  logic             w_load_entry;
  logic             w_sample;
  logic [SW-1:0]    w_stable_nxt;
  logic             w_update;

  assign w_run        = (r_state == ST_LOAD) || (r_state == ST_SHIFT);
  assign w_load_entry = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);
  assign w_sample     = (r_state == ST_SHIFT) && w_tick && !r_half;

  joy_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .tick  (w_tick)
  );

  // State and shift-clock phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_half  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_half  <= w_half_nxt;
    end
  end

  // Next-state logic; a scan always runs to the end of GAP before enable is looked at again
  always_comb begin
    w_state_nxt = r_state;
    w_half_nxt  = r_half;
    unique case (r_state)
      ST_IDLE: begin
        w_half_nxt = 1'b0;
        if (enable || scan_req) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_half_nxt = 1'b0;
        if (w_tick && r_load_tick) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (r_half && (r_bit_cnt == BIT_LAST)) begin
            w_state_nxt = ST_COMMIT;
            w_half_nxt  = 1'b0;
          end else begin
            w_half_nxt = ~r_half;
          end
        end
      end
      ST_COMMIT: begin
        w_half_nxt  = 1'b0;
        w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        w_half_nxt = 1'b0;
        if (r_gap_cnt == GAP_LAST) w_state_nxt = enable ? ST_LOAD : ST_IDLE;
      end
      default: begin
        w_half_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pin drivers registered from the next state so the chain sees clean flop outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_joy_clk    <= 1'b0;
      r_joy_load_n <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_joy_clk    <= (w_state_nxt == ST_SHIFT) && w_half_nxt;
      r_joy_load_n <= (w_state_nxt != ST_LOAD);
      r_busy       <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SHIFT) ||
                      (w_state_nxt == ST_COMMIT);
    end
  end

  // LOAD tick, bit and gap counters; each is cleared outside its own state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_tick <= 1'b0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
    end else begin
      if (r_state != ST_LOAD)  r_load_tick <= 1'b0;
      else if (w_tick)         r_load_tick <= ~r_load_tick;

      if (r_state != ST_SHIFT) r_bit_cnt <= '0;
      else if (w_tick && r_half) r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;

      if (r_state != ST_GAP)   r_gap_cnt <= '0;
      else                     r_gap_cnt <= (r_gap_cnt == GAP_LAST) ? '0 : r_gap_cnt + 1'b1;
    end
  end

  // Deserialiser: chain is negative logic, first bit in ends up at the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
    end else if (w_load_entry) begin
      r_sreg <= '0;
    end else if (w_sample) begin
      r_sreg <= {r_sreg[NBITS-2:0], ~joy_data};
    end
  end

  assign w_stable_nxt = (r_sreg != r_raw_prev) ? DB_ONE :
                        (r_stable_cnt == DB_MAX) ? DB_MAX : r_stable_cnt + 1'b1;
  assign w_update     = (w_stable_nxt >= DB_MAX) && (r_sreg != r_frame_data);

  // Debounce and frame publication at the end of each scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw_prev      <= '0;
      r_stable_cnt    <= '0;
      r_frame_data    <= '0;
      r_frame_valid   <= 1'b0;
      r_frame_changed <= 1'b0;
    end else begin
      r_frame_valid   <= (r_state == ST_COMMIT);
      r_frame_changed <= (r_state == ST_COMMIT) && w_update;
      if (r_state == ST_COMMIT) begin
        r_raw_prev   <= r_sreg;
        r_stable_cnt <= w_stable_nxt;
        if (w_update) r_frame_data <= r_sreg;
      end
    end
  end

  assign joy_clk       = r_joy_clk;
  assign joy_load_n    = r_joy_load_n;
  assign frame_data    = r_frame_data;
  assign frame_valid   = r_frame_valid;
  assign frame_changed = r_frame_changed;
  assign busy          = r_busy;

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// tb/tb_joy_scan_ctrl.sv - directed bench for joy_scan_ctrl with serial chain models
module tb_joy_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  logic enable = 1'b0;
  logic scan_req = 1'b0;

  logic       jdata1, jclk1, jload1, fv1, fc1, busy1;
  logic [7:0] fd1;
  logic       jclk3, jload3, fv3, fc3, busy3;
  logic [7:0] fd3;
  logic        jdata2, jclk2, jload2, fv2, fc2, busy2;
  logic [23:0] fd2;

  logic [7:0]  par1 = 8'hFF;
  logic [7:0]  sr1;
  logic        pj1;
  logic [23:0] par2 = 24'hFFFFFF;
  logic [23:0] sr2;
  logic        pj2;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_rise = 0, n_load = 0, n_fv = 0, n_fc = 0, last_rise = 0, rise_per = 0;
  logic mp = 1'b0;

  always #5 clk = ~clk;

  joy_scan_ctrl #(.NBITS(8), .CLK_DIV(2), .GAP_CYC(4), .DEBOUNCE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .scan_req(scan_req), .joy_data(jdata1),
    .joy_clk(jclk1), .joy_load_n(jload1), .frame_data(fd1), .frame_valid(fv1),
    .frame_changed(fc1), .busy(busy1)
  );

  joy_scan_ctrl #(.NBITS(8), .CLK_DIV(2), .GAP_CYC(4), .DEBOUNCE(1)) u_dut_db1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .scan_req(scan_req), .joy_data(jdata1),
    .joy_clk(jclk3), .joy_load_n(jload3), .frame_data(fd3), .frame_valid(fv3),
    .frame_changed(fc3), .busy(busy3)
  );

  joy_scan_ctrl #(.NBITS(24), .CLK_DIV(16), .GAP_CYC(256), .DEBOUNCE(2)) u_dut_big (
    .clk(clk), .rst_n(rst2_n), .enable(enable), .scan_req(scan_req), .joy_data(jdata2),
    .joy_clk(jclk2), .joy_load_n(jload2), .frame_data(fd2), .frame_valid(fv2),
    .frame_changed(fc2), .busy(busy2)
  );

  // Parallel-load serial-out chain: loads while load_n is low, shifts on joy_clk rise, fills with 1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr1 <= 8'hFF;
      pj1 <= 1'b0;
    end else begin
      pj1 <= jclk1;
      if (!jload1) sr1 <= par1;
      else if (jclk1 && !pj1) sr1 <= {sr1[6:0], 1'b1};
    end
  end
  assign jdata1 = sr1[7];

  // Same chain model, 24 bits long, for the default-sized instance
  always @(posedge clk or negedge rst2_n) begin
    if (!rst2_n) begin
      sr2 <= 24'hFFFFFF;
      pj2 <= 1'b0;
    end else begin
      pj2 <= jclk2;
      if (!jload2) sr2 <= par2;
      else if (jclk2 && !pj2) sr2 <= {sr2[22:0], 1'b1};
    end
  end
  assign jdata2 = sr2[23];

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters on the small instance, sampled mid-cycle
  always @(negedge clk) begin
    if (jclk1 && !mp) begin
      rise_per  = cyc - last_rise;
      last_rise = cyc;
      n_rise++;
    end
    mp = jclk1;
    if (!jload1) n_load++;
    if (fv1) n_fv++;
    if (fc1) n_fc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sel: 0 fv small, 1 load_n small low, 2 fv big, 3 load_n big low
  task automatic wait_for(input int sel, input int limit, input string tag, output int t);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      #1;
      case (sel)
        0: hit = fv1;
        1: hit = !jload1;
        2: hit = fv2;
        default: hit = !jload2;
      endcase
    end
    t = cyc;
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rises(input int base, input int n, input int limit, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = (n_rise - base) >= n;
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int t0, t1, t2, b_load, b_rise, b_fc, b_fv;
    par2 = ~24'h800000;
    idle_cycles(3);

    check("rst_joy_clk", jclk1, 1'b0);
    check("rst_load_n", jload1, 1'b1);
    check("rst_frame", fd1, 8'h00);
    check("rst_fv", fv1, 1'b0);
    check("rst_fc", fc1, 1'b0);
    check("rst_busy", busy1, 1'b0);

    // 1: nothing pressed
    b_load = n_load; b_rise = n_rise; b_fc = n_fc;
    enable = 1'b1;
    rst_n = 1'b1;
    wait_for(1, 20, "t1_load", t0);
    wait_for(0, 100, "t1_fv", t1);
    check("t1_latency", t1 - t0, 37);
    check("t1_load_low", n_load - b_load, 4);
    check("t1_rises", n_rise - b_rise, 8);
    check("t1_period", rise_per, 4);
    check("t1_frame", fd1, 8'h00);
    check("t1_fc", n_fc - b_fc, 0);
    check("t1_busy", busy1, 1'b0);

    // 3: alternating scans never settle (DEBOUNCE=2); DEBOUNCE=1 follows each scan
    b_fc = n_fc;
    par1 = 8'hFE;
    wait_for(0, 100, "t3_fv_a", t1);
    check("t3_frame_a", fd1, 8'h00);
    check("t3_db1_a", fd3, 8'h01);
    par1 = 8'hFD;
    wait_for(0, 100, "t3_fv_b", t1);
    check("t3_frame_b", fd1, 8'h00);
    check("t3_db1_b", fd3, 8'h02);
    par1 = 8'hFE;
    wait_for(0, 100, "t3_fv_c", t1);
    check("t3_frame_c", fd1, 8'h00);
    check("t3_db1_c", fd3, 8'h01);
    check("t3_fc", n_fc - b_fc, 0);

    // 2: two identical scans of A5 pressed
    b_fc = n_fc;
    par1 = 8'h5A;
    wait_for(0, 100, "t2_fv_a", t1);
    check("t2_frame_a", fd1, 8'h00);
    check("t2_fc_a", n_fc - b_fc, 0);
    wait_for(0, 100, "t2_fv_b", t1);
    check("t2_frame_b", fd1, 8'hA5);
    check("t2_fc_b", n_fc - b_fc, 1);

    // 4: enable drops mid-shift; scan completes, then a one-shot request gives one scan
    par1 = 8'hC3;
    wait_for(1, 20, "t4_load", t0);
    b_rise = n_rise;
    wait_rises(b_rise, 3, 100, "t4_rise3");
    enable = 1'b0;
    wait_for(0, 100, "t4_fv", t1);
    check("t4_rises", n_rise - b_rise, 8);
    check("t4_frame", fd1, 8'hA5);
    idle_cycles(6);
    check("t4_idle_load_n", jload1, 1'b1);
    check("t4_idle_joy_clk", jclk1, 1'b0);
    check("t4_idle_busy", busy1, 1'b0);
    b_load = n_load;
    idle_cycles(20);
    check("t4_no_scan", n_load - b_load, 0);
    @(negedge clk); scan_req = 1'b1;
    @(negedge clk); scan_req = 1'b0;
    b_fv = n_fv;
    idle_cycles(60);
    check("t4_req_scans", n_fv - b_fv, 1);
    check("t4_req_frame", fd1, 8'h3C);

    // 5: asynchronous reset mid-shift
    enable = 1'b1;
    wait_for(1, 20, "t5_load", t0);
    b_rise = n_rise;
    wait_rises(b_rise, 4, 100, "t5_rise4");
    #2 rst_n = 1'b0;
    #1;
    check("t5_joy_clk", jclk1, 1'b0);
    check("t5_load_n", jload1, 1'b1);
    check("t5_frame", fd1, 8'h00);
    check("t5_busy", busy1, 1'b0);
    par1 = 8'hA5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_for(0, 100, "t5_fv_a", t1);
    check("t5_frame_a", fd1, 8'h00);
    wait_for(0, 100, "t5_fv_b", t1);
    check("t5_frame_b", fd1, 8'h5A);

    // 6: default sizing, continuous mode
    @(negedge clk);
    rst2_n = 1'b1;
    wait_for(3, 20, "t6_load", t0);
    wait_for(2, 1000, "t6_fv_a", t1);
    check("t6_latency", t1 - t0, 801);
    wait_for(2, 1200, "t6_fv_b", t2);
    check("t6_spacing", t2 - t1, 1057);
    check("t6_frame_msb", fd2, 24'h800000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
